axis_fifo_arbiter: RTL and testbench
====================================

# axis_fifo_arbiter

Packet-level round-robin arbiter that shares one write port of the synchronous FIFO between `NREQ` AXI-Stream sources. A grant locks to one source until that source's `tlast` beat is written, so packets never interleave. Each written FIFO word carries the source index and `tlast`, so the read side can demultiplex and delimit packets. Sits directly in front of the FIFO write interface (`i_wen`/`i_wdata`/`o_wfull`).

## Interface
- `NREQ`, 4: number of AXI-Stream sources; must be ≥2.
- `DLEN`, 8: payload width per beat.
- `IDW` (localparam), `$clog2(NREQ)`: source-index width.
- `FDLEN` (localparam), `DLEN+IDW+1`: FIFO word width; the FIFO is instantiated with `DLEN=FDLEN`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `s_tvalid`  in  NREQ  per-source valid.
- `s_tready`  out  NREQ  per-source ready; at most one bit high.
- `s_tdata`  in  NREQ*DLEN  source i occupies bits [i*DLEN +: DLEN].
- `s_tlast`  in  NREQ  per-source end-of-packet.
- `o_fifo_wen`  out  1  FIFO write strobe (to FIFO `i_wen`).
- `o_fifo_wdata`  out  FDLEN  {src_id, last, data} (to FIFO `i_wdata`).
- `i_fifo_wfull`  in  1  FIFO full flag (from FIFO `o_wfull`).
- `o_busy`  out  1  high while a source holds the grant.
- `o_grant_id`  out  IDW  currently or most recently granted source.

## Operation
- Two-state FSM: IDLE, LOCKED.
- IDLE: all `s_tready` low and `o_fifo_wen` low. If any `s_tvalid` is high, choose the first valid source scanning upward from `rr_ptr`, wrapping past NREQ-1 to 0. Register it into `grant`, then go to LOCKED. The `s_tlast` of the chosen source is ignored in this cycle.
- LOCKED: `s_tready[grant] = !i_fifo_wfull`; all other ready bits are 0.
  - Beat accepted = `s_tvalid[grant] && s_tready[grant]`.
  - `o_fifo_wen` = beat accepted (combinational).
  - `o_fifo_wdata` = {grant, `s_tlast[grant]`, `s_tdata[grant]`}.
  - On an accepted beat with `tlast`: go to IDLE and set `rr_ptr` to grant+1 mod NREQ.
  - Anything else: stay in LOCKED.
- A source that drops `tvalid` mid-packet keeps the grant. There is no timeout.
- `o_busy` = (state == LOCKED). `o_grant_id` = `grant`.
- Reset values: state IDLE, `grant`=0, `rr_ptr`=0, `s_tready`=0, `o_fifo_wen`=0, `o_busy`=0, `o_grant_id`=0.
- Reset asserted mid-packet: the FSM returns to IDLE and `rr_ptr` to 0. Beats already written stay in the FIFO. Flushing the FIFO is the integrator's job, since the FIFO shares the same `rstn`.

## Timing
- Arbitration costs one IDLE cycle per packet. The first beat of a packet is accepted no earlier than 1 cycle after `tvalid` is presented.
- In LOCKED with the FIFO not full, throughput is 1 beat per cycle.
- Back-to-back packets from any sources lose 1 cycle between the `tlast` beat and the next first beat.
- `s_tready` and `o_fifo_wen` are combinational from the registered state and `i_fifo_wfull`. `i_fifo_wfull` is registered inside the FIFO, so there is no combinational loop.
- Full flag: writes stall while `i_fifo_wfull`=1; `s_tready` goes low in the same cycle. The grant is held and resumes in the first cycle the flag is 0.
- Single-beat packets (`tlast` on the first beat) are legal and take 2 cycles: IDLE, then LOCKED.

## Structure
- Package `axis_fifo_pkg`:
  - state enum `arb_state_e` {IDLE, LOCKED};
  - function `fifo_word_w(DLEN, NREQ)`;
  - field-offset constants for {src_id, last, data}, so the read-side demux shares them.
- Sub-module `rr_pick`: purely combinational. Inputs are the NREQ-bit request vector and `rr_ptr`; outputs are `any` and `idx` (IDW bits). It is reused later by the read-side demux credit logic.
- FSM, grant/pointer registers and datapath mux stay in `axis_fifo_arbiter`.

## Test plan
- Reset, then source 2 sends 3 beats (0xA1, 0xA2, 0xA3 with `tlast`) → FIFO receives {2,0,A1}, {2,0,A2}, {2,1,A3} on 3 consecutive cycles starting 1 cycle after valid; `o_busy` drops after A3.
- All 4 sources valid with 1-beat packets continuously → grant order 0, 1, 2, 3, 0; one write every 2 cycles.
- Source 1 mid-packet while source 3 is valid → no beat from 3 is written until source 1's `tlast` beat is accepted; next grant goes to 3 (`rr_ptr`=2, 2 not valid).
- `i_fifo_wfull` held high for 5 cycles during source 0's packet → no `o_fifo_wen`, `s_tready[0]`=0 for those 5 cycles; grant is held; the data beat pending at stall start is written in the first cycle after full clears.
- `rstn` pulsed low asynchronously mid-packet (between clock edges) → `s_tready` and `o_fifo_wen` drop immediately; after release the FSM is IDLE, `o_grant_id`=0, and source 0 wins if all sources are valid.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared types and FIFO word layout for the AXI-Stream to FIFO arbiter and its read-side demux.
`timescale 1ns/1ps
package axis_fifo_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // FIFO word is {src_id, last, data}, data in the low bits.
    localparam int unsigned DATA_LSB = 0;

    function automatic int unsigned last_bit(input int unsigned dlen);
        return dlen;
    endfunction

    function automatic int unsigned id_lsb(input int unsigned dlen);
        return dlen + 1;
    endfunction

    function automatic int unsigned fifo_word_w(input int unsigned dlen, input int unsigned nreq);
        return dlen + $clog2(nreq) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_arbiter_rr_pick.sv
// Round-robin picker: first asserted request scanning upward from ptr, wrapping at NREQ-1.
`timescale 1ns/1ps
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    always_comb begin
        int j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            j = int'(rr_ptr) + k;
            if (j >= int'(NREQ)) j = j - int'(NREQ);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port between NREQ AXI-Stream sources.
`timescale 1ns/1ps
module axis_fifo_arbiter
    import axis_fifo_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned DLEN  = 8,
    localparam int unsigned IDW   = $clog2(NREQ),
    localparam int unsigned FDLEN = fifo_word_w(DLEN, NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      s_tvalid,
    output logic [NREQ-1:0]      s_tready,
    input  logic [NREQ*DLEN-1:0] s_tdata,
    input  logic [NREQ-1:0]      s_tlast,
    output logic                 o_fifo_wen,
    output logic [FDLEN-1:0]     o_fifo_wdata,
    input  logic                 i_fifo_wfull,
    output logic                 o_busy,
    output logic [IDW-1:0]       o_grant_id
);

    arb_state_e      state;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  rr_ptr;
    logic            pick_any;
    logic [IDW-1:0]  pick_idx;
    logic            accept;
    logic            sel_last;
    logic [DLEN-1:0] sel_data;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (s_tvalid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Ready/write strobe are combinational from registered state and the FIFO's registered full flag.
    always_comb begin
        s_tready     = '0;
        sel_data     = '0;
        sel_last     = s_tlast[grant];
        o_fifo_wdata = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant == IDW'(i)) sel_data = s_tdata[i*DLEN +: DLEN];
        end
        if (state == LOCKED) s_tready[grant] = !i_fifo_wfull;
        accept     = s_tvalid[grant] && s_tready[grant];
        o_fifo_wen = accept;
        o_fifo_wdata[DATA_LSB +: DLEN]   = sel_data;
        o_fifo_wdata[last_bit(DLEN)]     = sel_last;
        o_fifo_wdata[id_lsb(DLEN) +: IDW] = grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    // Grant is released only once the tlast beat has been written.
                    if (accept && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy     = (state == LOCKED);
    assign o_grant_id = grant;

endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Directed self-checking bench for axis_fifo_arbiter (NREQ=4, DLEN=8).
`timescale 1ns/1ps
module tb_axis_fifo_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DLEN  = 8;
    localparam int unsigned IDW   = 2;
    localparam int unsigned FDLEN = 11;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      s_tvalid;
    logic [NREQ-1:0]      s_tready;
    logic [NREQ*DLEN-1:0] s_tdata;
    logic [NREQ-1:0]      s_tlast;
    logic                 o_fifo_wen;
    logic [FDLEN-1:0]     o_fifo_wdata;
    logic                 i_fifo_wfull;
    logic                 o_busy;
    logic [IDW-1:0]       o_grant_id;

    int checks;
    int errors;

    axis_fifo_arbiter #(.NREQ(NREQ), .DLEN(DLEN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .o_fifo_wen   (o_fifo_wen),
        .o_fifo_wdata (o_fifo_wdata),
        .i_fifo_wfull (i_fifo_wfull),
        .o_busy       (o_busy),
        .o_grant_id   (o_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic v, input logic [7:0] d, input logic l);
        s_tvalid[i]         = v;
        s_tdata[i*8 +: 8]   = d;
        s_tlast[i]          = l;
    endtask

    // One cycle-level check of the write port and handshake; inputs already driven after negedge.
    task automatic chk_cycle(input string name, input logic exp_wen, input logic [FDLEN-1:0] exp_wdata,
                             input logic [NREQ-1:0] exp_rdy, input logic exp_busy);
        checks++;
        if (o_fifo_wen !== exp_wen) begin
            errors++;
            $display("FAIL %s wen: got %b expected %b", name, o_fifo_wen, exp_wen);
        end
        if (exp_wen) begin
            checks++;
            if (o_fifo_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL %s wdata: got %h expected %h", name, o_fifo_wdata, exp_wdata);
            end
        end
        checks++;
        if (s_tready !== exp_rdy) begin
            errors++;
            $display("FAIL %s tready: got %b expected %b", name, s_tready, exp_rdy);
        end
        checks++;
        if (o_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", name, o_busy, exp_busy);
        end
    endtask

    task automatic chk_gid(input string name, input logic [IDW-1:0] exp);
        checks++;
        if (o_grant_id !== exp) begin
            errors++;
            $display("FAIL %s grant_id: got %0d expected %0d", name, o_grant_id, exp);
        end
    endtask

    task automatic do_reset();
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; i_fifo_wfull = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; i_fifo_wfull = 1'b0;
        rstn = 1'b0;
        #12;
        chk_cycle("reset", 1'b0, '0, 4'b0000, 1'b0);
        chk_gid("reset", 2'd0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_source();
        @(negedge clk); set_src(2, 1'b1, 8'hA1, 1'b0); #1;
        chk_cycle("ss_idle", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("ss_a1", 1'b1, {2'd2, 1'b0, 8'hA1}, 4'b0100, 1'b1);
        @(negedge clk); set_src(2, 1'b1, 8'hA2, 1'b0); #1;
        chk_cycle("ss_a2", 1'b1, {2'd2, 1'b0, 8'hA2}, 4'b0100, 1'b1);
        @(negedge clk); set_src(2, 1'b1, 8'hA3, 1'b1); #1;
        chk_cycle("ss_a3", 1'b1, {2'd2, 1'b1, 8'hA3}, 4'b0100, 1'b1);
        @(negedge clk); set_src(2, 1'b0, 8'h00, 1'b0); #1;
        chk_cycle("ss_done", 1'b0, '0, 4'b0000, 1'b0);
        chk_gid("ss_done", 2'd2);
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] id;
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'h10 + 8'(i), 1'b1);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c % 2 == 0) begin
                chk_cycle("rr_idle", 1'b0, '0, 4'b0000, 1'b0);
            end else begin
                id = IDW'((c / 2) % 4);
                chk_cycle("rr_write", 1'b1, {id, 1'b1, 8'h10 + 8'(id)}, 4'b0001 << id, 1'b1);
            end
            @(negedge clk);
        end
        s_tvalid = '0; s_tlast = '0;
    endtask

    task automatic test_no_interleave();
        // rr_ptr is 1 here: source 1 wins, then 3 follows because 2 is idle.
        @(negedge clk);
        set_src(1, 1'b1, 8'hB1, 1'b0);
        set_src(3, 1'b1, 8'hC1, 1'b1);
        #1; chk_cycle("ni_idle", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("ni_b1", 1'b1, {2'd1, 1'b0, 8'hB1}, 4'b0010, 1'b1);
        @(negedge clk); set_src(1, 1'b0, 8'hB2, 1'b0); #1;
        chk_cycle("ni_gap", 1'b0, '0, 4'b0010, 1'b1);
        chk_gid("ni_gap", 2'd1);
        @(negedge clk); set_src(1, 1'b1, 8'hB2, 1'b1); #1;
        chk_cycle("ni_b2", 1'b1, {2'd1, 1'b1, 8'hB2}, 4'b0010, 1'b1);
        @(negedge clk); set_src(1, 1'b0, 8'h00, 1'b0); #1;
        chk_cycle("ni_idle2", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("ni_c1", 1'b1, {2'd3, 1'b1, 8'hC1}, 4'b1000, 1'b1);
        @(negedge clk); set_src(3, 1'b0, 8'h00, 1'b0); #1;
        chk_cycle("ni_done", 1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_full_stall();
        // rr_ptr is 0 here.
        @(negedge clk); set_src(0, 1'b1, 8'hD1, 1'b0); #1;
        chk_cycle("fs_idle", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("fs_d1", 1'b1, {2'd0, 1'b0, 8'hD1}, 4'b0001, 1'b1);
        @(negedge clk); set_src(0, 1'b1, 8'hD2, 1'b0); i_fifo_wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk_cycle("fs_stall", 1'b0, '0, 4'b0000, 1'b1);
            chk_gid("fs_stall", 2'd0);
            @(negedge clk);
        end
        i_fifo_wfull = 1'b0; #1;
        chk_cycle("fs_d2", 1'b1, {2'd0, 1'b0, 8'hD2}, 4'b0001, 1'b1);
        @(negedge clk); set_src(0, 1'b1, 8'hD3, 1'b1); #1;
        chk_cycle("fs_d3", 1'b1, {2'd0, 1'b1, 8'hD3}, 4'b0001, 1'b1);
        @(negedge clk); set_src(0, 1'b0, 8'h00, 1'b0); #1;
        chk_cycle("fs_done", 1'b0, '0, 4'b0000, 1'b0);
    endtask

    task automatic test_async_reset();
        // rr_ptr is 1 here; only source 2 is valid so it wins.
        @(negedge clk); set_src(2, 1'b1, 8'hE1, 1'b0); #1;
        chk_cycle("ar_idle", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("ar_e1", 1'b1, {2'd2, 1'b0, 8'hE1}, 4'b0100, 1'b1);
        @(negedge clk); set_src(2, 1'b1, 8'hE2, 1'b0); #1;
        chk_cycle("ar_e2", 1'b1, {2'd2, 1'b0, 8'hE2}, 4'b0100, 1'b1);
        #1 rstn = 1'b0;
        #1;
        chk_cycle("ar_inrst", 1'b0, '0, 4'b0000, 1'b0);
        chk_gid("ar_inrst", 2'd0);
        for (int i = 0; i < 4; i++) set_src(i, 1'b1, 8'h20 + 8'(i), 1'b0);
        #1 rstn = 1'b1;
        #0;
        chk_cycle("ar_release", 1'b0, '0, 4'b0000, 1'b0);
        @(negedge clk); #1;
        chk_cycle("ar_win0", 1'b1, {2'd0, 1'b0, 8'h20}, 4'b0001, 1'b1);
        chk_gid("ar_win0", 2'd0);
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_source();
        test_round_robin();
        test_no_interleave();
        test_full_stall();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
